// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1, LSB first, with a small byte FIFO in front.
// Frames go out back-to-back with a two-cycle high gap (CLEANUP + IDLE).
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | line high; pops the FIFO head when one is queued
// START   | start bit (0) for CLKS_PER_BIT cycles
// DATA    | data bits 0..7, CLKS_PER_BIT cycles each
// STOP    | stop bit (1) for CLKS_PER_BIT cycles
// CLEANUP | one cycle, tx_done pulse, line high
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_byte,
  output logic       tx_ready,
  output logic       TxD,
  output logic       tx_active,
  output logic       tx_done
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } state_t;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FCNT_W-1:0] fifo_cnt;
  logic              push;
  logic              pop;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              bit_end;

  // Ready depends only on the registered count, so a pop in a full cycle
  // does not open a write slot until the following cycle.
  assign tx_ready = (fifo_cnt != FIFO_FULL);
  assign push     = tx_valid && tx_ready;

  // FIFO storage; no reset needed, validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_byte;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FSM, bit timer, shift register and registered line output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  // Next-state logic; the line value is derived from the next state so
  // TxD changes on the same edge as the state it belongs to.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    txd_d   = 1'b1;
    bit_end = (cnt_q == CNT_LAST);

    case (state_q)
      S_IDLE: begin
        if (fifo_cnt != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_CLEANUP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CLEANUP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[idx_d];
      default: txd_d = 1'b1;
    endcase
  end

  assign TxD       = txd_q;
  assign tx_active = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
  assign tx_done   = (state_q == S_CLEANUP);

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with CLKS_PER_BIT=16, FIFO_DEPTH=4.
// A small serial receiver model decodes TxD into a queue of bytes.
module tb_uart_transmitter;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_ready;
  logic       TxD;
  logic       tx_active;
  logic       tx_done;

  int n_checks = 0;
  int n_errors = 0;

  uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_valid  (tx_valid),
    .tx_byte   (tx_byte),
    .tx_ready  (tx_ready),
    .TxD       (TxD),
    .tx_active (tx_active),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  // Receiver model: samples mid-bit relative to the first low cycle seen.
  logic       rx_busy = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rxq[$];
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_busy <= 1'b0;
      rx_cnt  <= 0;
    end else if (!rx_busy) begin
      if (TxD == 1'b0) begin
        rx_busy <= 1'b1;
        rx_cnt  <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt == CPB / 2 && TxD != 1'b0) begin
        rx_busy <= 1'b0;
      end else if (rx_cnt >= 24 && rx_cnt <= 136 && (rx_cnt - 24) % CPB == 0) begin
        rx_sh <= {TxD, rx_sh[7:1]};
      end else if (rx_cnt == 152) begin
        rx_busy <= 1'b0;
        if (TxD == 1'b1) rxq.push_back(rx_sh);
      end
    end
  end

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_byte  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 1000 && !tx_ready; i++) tick();
    check("push_ready", {31'd0, tx_ready}, 32'd1);
    tick();
    tx_valid = 1'b0;
  endtask

  // Fill with consecutive bytes starting at 'first' while holding valid;
  // returns how many were accepted and when ready first dropped.
  task automatic fill(input logic [7:0] first, input int cycles, output int acc, output int first_low);
    logic [7:0] b;
    b         = first;
    acc       = 0;
    first_low = -1;
    tx_byte   = b;
    tx_valid  = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      if (tx_ready) begin
        acc++;
        b = b + 8'd1;
      end else if (first_low < 0) begin
        first_low = c;
      end
      tick();
      tx_byte = b;
    end
  endtask

  task automatic check_rx_seq(input string tag, input logic [7:0] first, input int n);
    logic [7:0] got;
    check({tag, "_count"}, rxq.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (i < rxq.size()) ? rxq[i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, first + 8'(i)});
    end
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] exp_txd;
    logic [7:0] lb [4];
    logic [7:0] got;
    int mism_txd, mism_act, mism_done, act_cycles, done_at;
    int acc, first_low, d0, bad;

    // 1. reset values
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_txd",    {31'd0, TxD},       32'd1);
    check("rst_ready",  {31'd0, tx_ready},  32'd1);
    check("rst_active", {31'd0, tx_active}, 32'd0);
    check("rst_done",   {31'd0, tx_done},   32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 2. single byte 0xA5, cycle-exact
    rxq.delete();
    d0 = done_cnt;
    pat = 8'hA5;
    tx_byte  = pat;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("a5_lat0_txd", {31'd0, TxD}, 32'd1);
    mism_txd = 0; mism_act = 0; mism_done = 0; act_cycles = 0; done_at = -1;
    for (int k = 1; k <= 170; k++) begin
      tick();
      if (k <= CPB) exp_txd = 8'd0;
      else if (k <= 9 * CPB) exp_txd = {7'd0, pat[(k - CPB - 1) / CPB]};
      else exp_txd = 8'd1;
      if ({7'd0, TxD} != exp_txd) mism_txd++;
      if (tx_active != (k <= 10 * CPB)) mism_act++;
      if (tx_active) act_cycles++;
      if (tx_done != (k == 10 * CPB + 1)) mism_done++;
      if (tx_done && done_at < 0) done_at = k;
    end
    check("a5_txd_mismatches",    mism_txd,   0);
    check("a5_active_mismatches", mism_act,   0);
    check("a5_done_mismatches",   mism_done,  0);
    check("a5_active_cycles",     act_cycles, 160);
    check("a5_done_at",           done_at,    161);
    check("a5_done_pulses",       done_cnt - d0, 1);
    check_rx_seq("a5_rx", 8'hA5, 1);

    // 3. fill FIFO with 0x01..0x06 held valid
    rxq.delete();
    d0 = done_cnt;
    fill(8'h01, 20, acc, first_low);
    tx_valid = 1'b0;
    check("fill_accepted",  acc,       5);
    check("fill_first_low", first_low, 5);
    check("fill_ready_low", {31'd0, tx_ready}, 32'd0);
    repeat (5 * FRAME + 30) tick();
    check_rx_seq("fill_rx", 8'h01, 5);
    check("fill_done_pulses", done_cnt - d0, 5);

    // 4. full FIFO + pop in the same cycle: write deferred one cycle
    rxq.delete();
    d0 = done_cnt;
    fill(8'h31, 12, acc, first_low);
    check("fp_accepted", acc, 5);
    check("fp_pending_byte", {24'd0, tx_byte}, 32'h36);
    for (int i = 0; i < 400 && !tx_done; i++) tick();
    check("fp_done_seen", {31'd0, tx_done}, 32'd1);
    tick();
    check("fp_idle_ready", {31'd0, tx_ready}, 32'd0);
    tick();
    check("fp_after_pop_ready", {31'd0, tx_ready}, 32'd1);
    tick();
    check("fp_after_write_ready", {31'd0, tx_ready}, 32'd0);
    tx_valid = 1'b0;
    repeat (5 * FRAME + 30) tick();
    check_rx_seq("fp_rx", 8'h31, 6);
    check("fp_done_pulses", done_cnt - d0, 6);

    // 5. reset during data bit 3 of 0x00 with more bytes queued
    rxq.delete();
    push_byte(8'h00);
    push_byte(8'h11);
    push_byte(8'h22);
    repeat (68) tick();
    d0 = done_cnt;
    check("mr_active_before", {31'd0, tx_active}, 32'd1);
    check("mr_txd_before",    {31'd0, TxD},       32'd0);
    rst_n = 1'b0;
    tick();
    check("mr_txd",    {31'd0, TxD},       32'd1);
    check("mr_ready",  {31'd0, tx_ready},  32'd1);
    check("mr_active", {31'd0, tx_active}, 32'd0);
    check("mr_done",   {31'd0, tx_done},   32'd0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (TxD != 1'b1 || tx_active || tx_done) bad++;
    end
    check("mr_line_idle_after", bad, 0);
    check("mr_no_done", done_cnt - d0, 0);
    check("mr_rx_empty", rxq.size(), 0);
    push_byte(8'hFF);
    repeat (FRAME + 10) tick();
    check_rx_seq("mr_ff_rx", 8'hFF, 1);
    check("mr_ff_done", done_cnt - d0, 1);

    // 6. loopback of edge patterns
    rxq.delete();
    d0 = done_cnt;
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h55; lb[3] = 8'h80;
    for (int i = 0; i < 4; i++) push_byte(lb[i]);
    repeat (4 * FRAME + 30) tick();
    check("lb_count", rxq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      got = (i < rxq.size()) ? rxq[i] : 8'hxx;
      check($sformatf("lb_byte%0d", i), {24'd0, got}, {24'd0, lb[i]});
    end
    check("lb_done_pulses", done_cnt - d0, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
